// File: rtl/id_regfile_sb.sv
`default_nettype none
// ============================================================================
// Module   : id_regfile_sb
// Brief    : Decode-stage integer register file. Registered read ports with a
//            same-edge writeback bypass, x0 hardwired to zero, and an optional
//            busy-bit scoreboard that raises a combinational stall when an
//            enabled source register still has a producer in flight.
//            Optional feature macro: REGFILE_SCOREBOARD_EN
//              defined   -> busy flops, stall and issue tracking are built
//              undefined -> busy = 0, stall = 0, issue inputs ignored
// Revision : 1.0 - initial release
// ============================================================================
module id_regfile_sb #(
  parameter int XLEN = 64,
  parameter int NREG = 32,
  parameter int NRD  = 2,
  parameter int AW   = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD-1:0]      i_rd_en,
  input  logic [NRD*AW-1:0]   i_rd_addr,
  output logic [NRD*XLEN-1:0] o_rd_data,
  output logic [NRD-1:0]      o_rd_valid,
  input  logic                i_wr_en,
  input  logic [AW-1:0]       i_wr_addr,
  input  logic [XLEN-1:0]     i_wr_data,
  input  logic                i_iss_en,
  input  logic [AW-1:0]       i_iss_rd,
  output logic [NREG-1:0]     o_busy,
  output logic                o_stall
);

  localparam logic [AW-1:0] c_X0 = '0;

  logic [XLEN-1:0]     r_rf [NREG];
  logic [NRD*XLEN-1:0] r_rd_data;
  logic [NRD-1:0]      r_rd_valid;
  logic                w_wr_live;
  logic                w_stall;

  // A write to x0 is discarded everywhere, including the bypass compare.
  assign w_wr_live = i_wr_en && (i_wr_addr != c_X0);

  // Architectural state update; x0 is never written so it stays at reset zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) begin
        r_rf[r] <= '0;
      end
    end else if (w_wr_live) begin
      r_rf[i_wr_addr] <= i_wr_data;
    end
  end

  // Registered read ports: zero for x0, bypass from writeback, else array.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_data  <= '0;
      r_rd_valid <= '0;
    end else begin
      for (int p = 0; p < NRD; p++) begin
        if (i_rd_addr[p*AW +: AW] == c_X0) begin
          r_rd_data[p*XLEN +: XLEN] <= '0;
        end else if (w_wr_live && (i_wr_addr == i_rd_addr[p*AW +: AW])) begin
          r_rd_data[p*XLEN +: XLEN] <= i_wr_data;
        end else begin
          r_rd_data[p*XLEN +: XLEN] <= r_rf[i_rd_addr[p*AW +: AW]];
        end
      end
      r_rd_valid <= i_rd_en & ~{NRD{w_stall}};
    end
  end

  assign o_rd_data  = r_rd_data;
  assign o_rd_valid = r_rd_valid;

`ifdef REGFILE_SCOREBOARD_EN
  logic [NREG-1:0] r_busy;

  // Stall when any enabled source is busy and not being written back now;
  // a same-edge writeback is covered by the bypass.
  always_comb begin
    w_stall = 1'b0;
    for (int p = 0; p < NRD; p++) begin
      if (i_rd_en[p] && r_busy[i_rd_addr[p*AW +: AW]] &&
          !(i_wr_en && (i_wr_addr == i_rd_addr[p*AW +: AW]))) begin
        w_stall = 1'b1;
      end
    end
  end

  // Busy bits: accepted issue sets (and beats a same-cycle clear), writeback clears.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= '0;
    end else begin
      r_busy[0] <= 1'b0;
      for (int r = 1; r < NREG; r++) begin
        if (i_iss_en && !w_stall && (i_iss_rd == AW'(r))) begin
          r_busy[r] <= 1'b1;
        end else if (i_wr_en && (i_wr_addr == AW'(r))) begin
          r_busy[r] <= 1'b0;
        end
      end
    end
  end

  assign o_busy = r_busy;
`else
  logic w_unused_iss;

  // Issue tracking is not built in this configuration.
  assign w_unused_iss = ^{i_iss_en, i_iss_rd};
  assign w_stall      = 1'b0;
  assign o_busy       = '0;
`endif

  assign o_stall = w_stall;

endmodule
`default_nettype wire

// File: tb/tb_id_regfile_sb.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_regfile_sb
// Brief    : Directed self-checking bench for id_regfile_sb (default params).
//            Expectations for the scoreboard follow REGFILE_SCOREBOARD_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_id_regfile_sb;

  localparam int XLEN = 64;
  localparam int NREG = 32;
  localparam int NRD  = 2;
  localparam int AW   = 5;

  logic                clk;
  logic                rst;
  logic [NRD-1:0]      rd_en;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_valid;
  logic                wr_en;
  logic [AW-1:0]       wr_addr;
  logic [XLEN-1:0]     wr_data;
  logic                iss_en;
  logic [AW-1:0]       iss_rd;
  logic [NREG-1:0]     busy;
  logic                stall;

  int n_vec;
  int n_err;

  id_regfile_sb #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD)) dut (
    .clk       (clk),
    .rst       (rst),
    .i_rd_en   (rd_en),
    .i_rd_addr (rd_addr),
    .o_rd_data (rd_data),
    .o_rd_valid(rd_valid),
    .i_wr_en   (wr_en),
    .i_wr_addr (wr_addr),
    .i_wr_data (wr_data),
    .i_iss_en  (iss_en),
    .i_iss_rd  (iss_rd),
    .o_busy    (busy),
    .o_stall   (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [XLEN-1:0] port(input int p);
    return rd_data[p*XLEN +: XLEN];
  endfunction

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1; rd_en = '0; rd_addr = '0; wr_en = 1'b0; wr_addr = '0;
    wr_data = '0; iss_en = 1'b0; iss_rd = '0;
    #12;
    chk("reset_rd_data", rd_data, 0);
    chk("reset_rd_valid", rd_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_stall", stall, 0);
    rst = 1'b0;

    // Reset then read x5 / x0.
    rd_en = 2'b11; rd_addr = {5'd0, 5'd5};
    tick();
    chk("rd_after_reset_data", rd_data, 0);
    chk("rd_after_reset_valid", rd_valid, 2'b11);
    chk("rd_after_reset_busy", busy, 0);

    // Write x7, read it back on port 1 the next cycle.
    rd_en = 2'b00; wr_en = 1'b1; wr_addr = 5'd7; wr_data = 64'hDEAD_BEEF;
    tick();
    wr_en = 1'b0; rd_en = 2'b10; rd_addr = {5'd7, 5'd5};
    tick();
    chk("rf_readback_x7", port(1), 64'hDEAD_BEEF);
    chk("rf_readback_valid", rd_valid, 2'b10);

    // Write to x0 is ignored, both on the bypass and in the array.
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 64'h1; rd_en = 2'b01; rd_addr = {5'd7, 5'd0};
    tick();
    chk("x0_bypass_zero", port(0), 0);
    wr_en = 1'b0;
    tick();
    chk("x0_array_zero", port(0), 0);
    chk("x7_still_held", port(1), 64'hDEAD_BEEF);

    // Same-edge bypass, then the array copy.
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 64'h55; rd_addr = {5'd0, 5'd3};
    tick();
    chk("bypass_x3", port(0), 64'h55);
    wr_en = 1'b0;
    tick();
    chk("array_x3", port(0), 64'h55);

`ifdef REGFILE_SCOREBOARD_EN
    // Issue x9 -> busy.
    rd_en = 2'b00; iss_en = 1'b1; iss_rd = 5'd9;
    tick();
    chk("issue_sets_busy9", busy, 32'h0000_0200);
    iss_en = 1'b0;
    rd_en = 2'b01; rd_addr = {5'd0, 5'd9};
    #1;
    chk("hazard_stall", stall, 1'b1);
    tick();
    chk("hazard_rd_valid", rd_valid, 2'b00);
    chk("hazard_busy_held", busy, 32'h0000_0200);
    // Writeback x9 on the same edge as the read: no stall, bypassed data.
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 64'hA5;
    #1;
    chk("wb_clears_stall", stall, 1'b0);
    tick();
    chk("wb_bypass_x9", port(0), 64'hA5);
    chk("wb_rd_valid", rd_valid, 2'b01);
    chk("wb_busy_cleared", busy, 0);

    // Set/clear collision on x4: set wins.
    wr_en = 1'b0; rd_en = 2'b00; iss_en = 1'b1; iss_rd = 5'd4;
    tick();
    chk("issue_sets_busy4", busy, 32'h0000_0010);
    wr_en = 1'b1; wr_addr = 5'd4; wr_data = 64'h7;
    tick();
    chk("collision_set_wins", busy, 32'h0000_0010);

    // Issue of x12 while stalled on x4 is dropped.
    wr_en = 1'b0; rd_en = 2'b01; rd_addr = {5'd0, 5'd4}; iss_rd = 5'd12;
    #1;
    chk("stall_on_x4", stall, 1'b1);
    tick();
    chk("issue_dropped", busy, 32'h0000_0010);
    chk("stalled_rd_valid", rd_valid, 2'b00);

    // Clear x4, then build busy on x9 and x12.
    iss_en = 1'b0; rd_en = 2'b00; wr_en = 1'b1; wr_addr = 5'd4; wr_data = 64'h8;
    tick();
    chk("x4_cleared", busy, 0);
    wr_en = 1'b0; iss_en = 1'b1; iss_rd = 5'd9;
    tick();
    iss_rd = 5'd12;
    tick();
    chk("busy_9_12", busy, 32'h0000_1200);
    iss_en = 1'b0; rd_en = 2'b01; rd_addr = {5'd0, 5'd5};
    tick();
    chk("pre_reset_valid", rd_valid, 2'b01);
`else
    // Issue inputs have no effect; stall never rises.
    rd_en = 2'b00; iss_en = 1'b1; iss_rd = 5'd9;
    tick();
    chk("noen_busy_zero", busy, 0);
    rd_en = 2'b01; rd_addr = {5'd0, 5'd9};
    #1;
    chk("noen_stall_zero", stall, 1'b0);
    tick();
    chk("noen_rd_valid", rd_valid, 2'b01);
    chk("noen_busy_still_zero", busy, 0);
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 64'hA5;
    tick();
    chk("noen_bypass_x9", port(0), 64'hA5);
    wr_en = 1'b0; iss_en = 1'b0; rd_addr = {5'd3, 5'd9};
    tick();
    chk("noen_pre_reset_data", port(1), 64'h55);
`endif

    // Asynchronous reset mid-cycle.
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_busy", busy, 0);
    chk("async_rst_valid", rd_valid, 0);
    chk("async_rst_data", rd_data, 0);
    chk("async_rst_stall", stall, 0);
    @(negedge clk);
    rst = 1'b0;
    rd_en = 2'b11; rd_addr = {5'd3, 5'd7};
    tick();
    chk("rf_cleared_x7", port(0), 0);
    chk("rf_cleared_x3", port(1), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Hard bound so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/id_regfile_sb.md
# id_regfile_sb

Parametrised decode-stage integer register file with a write-through bypass, multiple registered read ports and an optional busy-bit scoreboard. It sits in the ID stage between fetch/decode and execute. It takes source addresses from the decoder and the writeback port from WB. It delivers operand data one clock later and raises a stall when a source register has an outstanding producer.

## Interface
Parameters:
- XLEN, 64, data width of each register.
- NREG, 32, number of architectural registers; power of two, at least 2. AW = $clog2(NREG).
- NRD, 2, number of read ports, 1..4.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- rd_en  in  NRD  per-port read request.
- rd_addr  in  NRD*AW  packed read addresses; port i is [i*AW +: AW].
- rd_data  out  NRD*XLEN  packed registered read data.
- rd_valid  out  NRD  rd_data for port i is valid this cycle.
- wr_en  in  1  writeback strobe.
- wr_addr  in  AW  writeback destination.
- wr_data  in  XLEN  writeback value.
- iss_en  in  1  decoder issues an instruction that writes iss_rd.
- iss_rd  in  AW  destination register of the issuing instruction.
- busy  out  NREG  scoreboard bits; bit r=1 means register r has a pending write.
- stall  out  1  combinational; at least one enabled source is busy.

## Operation
- Register 0 reads as 0, ignores writes and is never marked busy.
- Write: on clock edge, if wr_en and wr_addr!=0, RF[wr_addr] <= wr_data.
- Read, per port i, on clock edge:
  - rd_data[i] <= 0 if addr==0.
  - Otherwise rd_data[i] <= wr_data if wr_en and wr_addr==addr (same-cycle bypass).
  - Otherwise rd_data[i] <= RF[addr].
  - rd_data updates every cycle regardless of rd_en.
- rd_valid[i] <= rd_en[i] & ~stall.
- Stall: stall = OR over i of (rd_en[i] & busy[addr_i] & ~(wr_en & wr_addr==addr_i)). A busy bit being cleared this cycle by writeback does not stall, because the bypass supplies the value.
- Scoreboard, per register r!=0, next busy[r]:
  - set if iss_en & ~stall & iss_rd==r;
  - else cleared if wr_en & wr_addr==r;
  - else hold.
  - Set and clear of the same register in one cycle: set wins, since a new producer is now in flight.
- An issue while stall=1 is dropped. The decoder holds iss_en/iss_rd until stall falls.
- Writeback to a non-busy register is legal: RF is written, busy is unchanged.

## Timing
- Read latency: 1 clock from address to rd_data/rd_valid.
- Write visible to RF reads the cycle after the edge. The bypass makes it visible to reads sampled on the same edge.
- stall is purely combinational from rd_en, rd_addr, busy, wr_en and wr_addr. There is no combinational path from iss_* to stall.
- Reset (async assert, released synchronously by the system):
  - all RF entries = 0;
  - rd_data = 0, rd_valid = 0, busy = 0, hence stall = 0.
- Reset mid-operation discards all pending busy bits and in-flight read results.

## Configuration
- REGFILE_SCOREBOARD_EN defined: scoreboard, busy and stall behave as above.
- REGFILE_SCOREBOARD_EN undefined:
  - no busy flops are built; busy is tied to 0 and stall to 0;
  - iss_en/iss_rd are ignored;
  - rd_valid[i] <= rd_en[i].
  - Read/write/bypass behaviour is identical in both builds.

## Test plan
- Reset then read: assert rst, release, rd_en=2'b11, addrs 5 and 0 -> next cycle rd_data = {0,0}, rd_valid=2'b11, busy=0.
- Write/read back: write x7=64'hDEAD_BEEF; next cycle read x7 on port 1 -> rd_data[1]=64'hDEAD_BEEF. Write x0=64'h1, read x0 -> 0.
- Bypass: same cycle wr_en, wr_addr=3, wr_data=64'h55, read port 0 addr 3 -> next cycle rd_data[0]=64'h55.
- Scoreboard hazard (EN build):
  - issue iss_rd=9 -> busy[9]=1;
  - read x9 with rd_en -> stall=1, rd_valid=0;
  - writeback x9=64'hA5 in the same cycle as the read -> stall=0, rd_data=64'hA5, busy[9]=0 after the edge.
- Set/clear collision: busy[4]=1; iss_rd=4 issues and wr_addr=4 writes back in one cycle -> busy[4] stays 1. Also issue during stall -> busy unchanged.
- Reset mid-op: busy[9]=busy[12]=1, assert rst asynchronously mid-cycle -> busy=0, rd_valid=0 immediately. Non-EN build: iss_en=1 has no effect, stall never 1.
